zapper_sense: RTL and testbench
===============================

// Module: zapper_sense
// PURPOSE
//  Light-gun (Zapper) photodiode model. Consumes the final RGB pixel stream and PPU beam
//  counters that feed the video mixer. Detects a bright pixel inside a square aperture
//  centred on the aim point, then holds the light flag for a fixed number of scanlines.
//  Also stretches trigger presses to whole frames. Outputs go to the $4017 input logic,
//  which inverts `light` to form the active-low bit.
// PARAMETERS
//  RADIUS       2      half-width of aperture in pixels/lines (window = 2*RADIUS+1 square)
//  THRESHOLD    160    minimum luma (0..255) that counts as a hit
//  HOLD_LINES   20     scanline starts counted before light drops
//  TRIG_FRAMES  4      frames trigger_out stays high per press
// PORTS
//  clk          in   1  system clock
//  reset_n      in   1  asynchronous active-low reset
//  ce_pix       in   1  pixel strobe; all state advances only when high
//  count_h      in   9  beam column 0..340
//  count_v      in   9  beam line 0..261 (511 = pre-render)
//  r,g,b        in   8  displayed pixel colour, aligned with count_h/count_v
//  aim_x        in   9  aim column
//  aim_y        in   9  aim line
//  trigger_in   in   1  raw trigger switch, level, async to frame
//  light        out  1  1 = light sensed
//  trigger_out  out  1  1 = trigger pulled, frame-stretched
//  hold_cnt     out  5  remaining hold lines (debug)
// BEHAVIOUR
//  Reset: light=0, trigger_out=0, hold_cnt=0, FSM=IDLE, trigger sync/edge regs=0,
//   trig_frames=0. Reset is async assert and takes effect mid-hold or mid-pulse.
//  Luma: y = (r + 2*g + b) >> 2, computed in 10 bits, result 8 bits, no rounding.
//  Aperture: |count_h-aim_x| <= RADIUS and |count_v-aim_y| <= RADIUS.
//   Use signed 10-bit differences; no wrap across line or frame edges.
//  Visible gate: a pixel counts only if count_h<256 and count_v<240.
//   If aim_x>=256 or aim_y>=240, no hit is ever produced.
//  hit = ce_pix & in_aperture & visible & (y >= THRESHOLD).
//  line_start = ce_pix & (count_h == 0).
//  FSM:
//   IDLE: on hit, go to HOLD, light=1, hold_cnt=HOLD_LINES.
//   HOLD: on hit, reload hold_cnt=HOLD_LINES.
//    Else on line_start, decrement hold_cnt.
//    When hold_cnt reaches 0, go to IDLE and set light=0 on that same edge.
//   hit and line_start in the same cycle: reload wins.
//  Latency: light rises on the clk edge that samples the qualifying ce_pix cycle.
//   It is visible in the next cycle. The pixel path has no extra pipeline.
//  Trigger: 2-flop synchroniser, then rising-edge detect.
//   frame_start = ce_pix & count_v==0 & count_h==0.
//   On an edge with trig_frames==0: trigger_out=1, trig_frames=TRIG_FRAMES.
//   Each frame_start while trig_frames>0 decrements it.
//   trigger_out drops on the edge where it reaches 0.
//   Edges are ignored while trig_frames>0.
//   Edge and frame_start in the same cycle with trig_frames==0: load TRIG_FRAMES, no decrement.
//  With ce_pix low, no state changes except the trigger synchroniser flops.
//  Counter widths: hold_cnt 5 bits (HOLD_LINES<=31); trig_frames 4 bits (TRIG_FRAMES<=15).
// TESTING
//  1 aim=(100,100); white pixel (255,255,255) at (101,99) -> light=1 next cycle; hold_cnt=20.
//  2 Same hit, then all black -> light stays 1 for exactly 20 line_starts, drops at the 20th.
//  3 Pixel luma 159 inside window, then 160 -> no hit at 159, hit at 160.
//    White pixel at (103,100) -> no hit (outside RADIUS).
//  4 aim=(300,100) with a full white frame -> light never asserts.
//    aim=(0,0), white at (0,0) -> hit, no wrap false-hit at (340,261).
//  5 In HOLD with hold_cnt=1, hit coincides with line_start -> hold_cnt=20, light stays 1.
//  6 trigger_in pulse of 3 clocks -> trigger_out high for 4 frame_starts.
//    Second press while high -> ignored. reset_n low mid-pulse -> trigger_out=0 immediately.

Source files
------------

// File: rtl/zapper_sense_if.sv
// Video-side bundle feeding the Zapper photodiode model: beam position, pixel colour,
// aim point and trigger in; light/trigger status and hold counter out.
interface zapper_sense_if;
  logic       ce_pix;
  logic [8:0] count_h;
  logic [8:0] count_v;
  logic [7:0] r;
  logic [7:0] g;
  logic [7:0] b;
  logic [8:0] aim_x;
  logic [8:0] aim_y;
  logic       trigger_in;
  logic       light;
  logic       trigger_out;
  logic [4:0] hold_cnt;

  modport master (
    output ce_pix, count_h, count_v, r, g, b, aim_x, aim_y, trigger_in,
    input  light, trigger_out, hold_cnt
  );

  modport slave (
    input  ce_pix, count_h, count_v, r, g, b, aim_x, aim_y, trigger_in,
    output light, trigger_out, hold_cnt
  );
endinterface

// File: rtl/zapper_sense.sv
// Zapper light-gun model: senses a bright pixel inside a square aperture around the aim
// point, holds the light flag for a number of scanlines, and frame-stretches trigger presses.
module zapper_sense #(
  parameter int RADIUS      = 2,
  parameter int THRESHOLD   = 160,
  parameter int HOLD_LINES  = 20,
  parameter int TRIG_FRAMES = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  zapper_sense_if.slave  bus
);

  localparam logic signed [9:0] RAD_POS = 10'(RADIUS);
  localparam logic signed [9:0] RAD_NEG = -10'(RADIUS);
  localparam logic [9:0]        LUMA_MIN_SUM = 10'(THRESHOLD * 4);
  localparam logic [4:0]        HOLD_LOAD = 5'(HOLD_LINES);
  localparam logic [3:0]        TRIG_LOAD = 4'(TRIG_FRAMES);

  typedef enum logic {IDLE, HOLD} state_t;

  // Pixel qualification (purely combinational, no pipeline stage)
  logic [9:0]        luma_sum;
  logic signed [9:0] dx, dy;
  logic              bright, in_aperture, visible, hit, line_start, frame_start;

  assign luma_sum = {2'b00, bus.r} + {1'b0, bus.g, 1'b0} + {2'b00, bus.b};
  // floor(sum/4) >= THRESHOLD is exactly sum >= 4*THRESHOLD, so the shift is never needed
  assign bright   = (luma_sum >= LUMA_MIN_SUM);

  assign dx = $signed({1'b0, bus.count_h}) - $signed({1'b0, bus.aim_x});
  assign dy = $signed({1'b0, bus.count_v}) - $signed({1'b0, bus.aim_y});
  assign in_aperture = (dx >= RAD_NEG) && (dx <= RAD_POS) &&
                       (dy >= RAD_NEG) && (dy <= RAD_POS);

  // An off-screen aim point must never hit, even when edge pixels fall inside its window
  assign visible = (bus.count_h < 9'd256) && (bus.count_v < 9'd240) &&
                   (bus.aim_x   < 9'd256) && (bus.aim_y   < 9'd240);

  assign hit         = bus.ce_pix && in_aperture && visible && bright;
  assign line_start  = bus.ce_pix && (bus.count_h == 9'd0);
  assign frame_start = line_start && (bus.count_v == 9'd0);

  // Light hold FSM
  state_t     state_q, state_d;
  logic [4:0] hold_q, hold_d;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          state_d = HOLD;
          hold_d  = HOLD_LOAD;
        end
      end
      HOLD: begin
        if (hit) begin
          hold_d = HOLD_LOAD;
        end else if (line_start) begin
          hold_d = hold_q - 5'd1;
          if (hold_q == 5'd1) state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        hold_d  = '0;
      end
    endcase
  end

  assign bus.light    = (state_q == HOLD);
  assign bus.hold_cnt = hold_q;

  // Trigger: the synchroniser runs every clock; edge history and frame stretch follow ce_pix,
  // so a press seen while ce_pix is low is still caught on the next pixel strobe.
  logic [1:0] trig_sync_q;
  logic       trig_prev_q;
  logic [3:0] trig_frames_q;
  logic       trig_edge;

  assign trig_edge = trig_sync_q[1] && !trig_prev_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trig_sync_q   <= '0;
      trig_prev_q   <= 1'b0;
      trig_frames_q <= '0;
    end else begin
      trig_sync_q <= {trig_sync_q[0], bus.trigger_in};
      if (bus.ce_pix) begin
        trig_prev_q <= trig_sync_q[1];
        if (trig_frames_q == '0) begin
          if (trig_edge) trig_frames_q <= TRIG_LOAD;
        end else if (frame_start) begin
          trig_frames_q <= trig_frames_q - 4'd1;
        end
      end
    end
  end

  assign bus.trigger_out = (trig_frames_q != '0);

endmodule

// File: tb/tb_zapper_sense.sv
// Self-checking bench for zapper_sense: table-driven pixel vectors plus hand-written
// hold, reload, off-screen, trigger and async-reset sequences, scored through a queue.
module tb_zapper_sense;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  zapper_sense_if bus();

  zapper_sense dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string      name;
    logic [8:0] h;
    logic [8:0] v;
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic       ce;
    logic       trig;
    logic       e_light;
    logic [4:0] e_hold;
    logic       e_trig;
  } vec_t;

  typedef struct {
    string      name;
    logic       e_light;
    logic [4:0] e_hold;
    logic       e_trig;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(string name, int h, int v, int r, int g, int b, bit ce, bit trig,
                              bit el, int eh, bit et);
    vec_t t;
    t.name = name; t.h = 9'(h); t.v = 9'(v);
    t.r = 8'(r); t.g = 8'(g); t.b = 8'(b);
    t.ce = ce; t.trig = trig;
    t.e_light = el; t.e_hold = 5'(eh); t.e_trig = et;
    return t;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one pixel cycle, queue its expectation, compare just after the sampling edge
  task automatic step(vec_t t);
    exp_t e;
    @(negedge clk);
    bus.ce_pix = t.ce; bus.count_h = t.h; bus.count_v = t.v;
    bus.r = t.r; bus.g = t.g; bus.b = t.b; bus.trigger_in = t.trig;
    sb.push_back('{t.name, t.e_light, t.e_hold, t.e_trig});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({e.name, ".light"},       32'(bus.light),       32'(e.e_light));
    check({e.name, ".hold_cnt"},    32'(bus.hold_cnt),    32'(e.e_hold));
    check({e.name, ".trigger_out"}, 32'(bus.trigger_out), 32'(e.e_trig));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.ce_pix = 1'b0; bus.count_h = 9'd5; bus.count_v = 9'd5;
    bus.r = '0; bus.g = '0; bus.b = '0; bus.trigger_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset.light",       32'(bus.light),       32'd0);
    check("reset.hold_cnt",    32'(bus.hold_cnt),    32'd0);
    check("reset.trigger_out", 32'(bus.trigger_out), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic set_aim(int x, int y);
    bus.aim_x = 9'(x);
    bus.aim_y = 9'(y);
  endtask

  vec_t tbl[$];
  bit   ever_lit;

  initial begin
    reset_n = 1'b0;
    set_aim(100, 100);

    // Aperture, threshold and ce_pix gating around aim (100,100)
    tbl.push_back(mk("far_white",  50,  50, 255, 255, 255, 1, 0, 0,  0, 0));
    tbl.push_back(mk("outside_h", 103, 100, 255, 255, 255, 1, 0, 0,  0, 0));
    tbl.push_back(mk("outside_v", 100,  97, 255, 255, 255, 1, 0, 0,  0, 0));
    tbl.push_back(mk("luma159",   101,  99, 159, 159, 159, 1, 0, 0,  0, 0));
    tbl.push_back(mk("luma_trunc",101,  99, 161, 160, 158, 1, 0, 0,  0, 0));
    tbl.push_back(mk("ce_low_hit",101,  99, 255, 255, 255, 0, 0, 0,  0, 0));
    tbl.push_back(mk("luma160",   101,  99, 160, 160, 160, 1, 0, 1, 20, 0));
    tbl.push_back(mk("line_dec",    0, 101,   0,   0,   0, 1, 0, 1, 19, 0));
    tbl.push_back(mk("mid_line",    5, 101,   0,   0,   0, 1, 0, 1, 19, 0));
    tbl.push_back(mk("ce_low_ls",   0, 102,   0,   0,   0, 0, 0, 1, 19, 0));
    tbl.push_back(mk("corner_hit", 98, 102, 255, 255, 255, 1, 0, 1, 20, 0));
    tbl.push_back(mk("line_dec2",   0, 103,   0,   0,   0, 1, 0, 1, 19, 0));
    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // Hold for exactly HOLD_LINES line starts after a single white hit
    do_reset();
    set_aim(100, 100);
    step(mk("hold_hit", 101, 99, 255, 255, 255, 1, 0, 1, 20, 0));
    for (int i = 1; i <= 20; i++) begin
      step(mk("hold_mid", 200, 110 + i, 0, 0, 0, 1, 0, 1, 21 - i, 0));
      step(mk("hold_ls",    0, 110 + i, 0, 0, 0, 1, 0, (i < 20), 20 - i, 0));
    end
    step(mk("hold_after", 0, 140, 0, 0, 0, 1, 0, 0, 0, 0));

    // Reload beats decrement when hit and line_start coincide at hold_cnt=1
    do_reset();
    set_aim(2, 100);
    step(mk("rl_hit", 2, 100, 255, 255, 255, 1, 0, 1, 20, 0));
    for (int i = 1; i <= 19; i++) step(mk("rl_ls", 0, 100, 0, 0, 0, 1, 0, 1, 20 - i, 0));
    step(mk("rl_coincide", 0, 101, 255, 255, 255, 1, 0, 1, 20, 0));
    step(mk("rl_next",     0, 102,   0,   0,   0, 1, 0, 1, 19, 0));

    // Off-screen aim never lights, even on a white band covering its rows
    do_reset();
    set_aim(300, 100);
    ever_lit = 1'b0;
    for (int v = 98; v <= 102; v++)
      for (int h = 0; h <= 340; h++) begin
        @(negedge clk);
        bus.ce_pix = 1'b1; bus.count_h = 9'(h); bus.count_v = 9'(v);
        bus.r = 8'hff; bus.g = 8'hff; bus.b = 8'hff;
        @(posedge clk);
        #1;
        if (bus.light) ever_lit = 1'b1;
      end
    check("offscreen_x.ever_lit", 32'(ever_lit), 32'd0);
    set_aim(100, 245);
    step(mk("aim_y_off",  100, 243, 255, 255, 255, 1, 0, 0, 0, 0));
    set_aim(100, 238);
    step(mk("invis_line", 100, 240, 255, 255, 255, 1, 0, 0, 0, 0));

    // Corner aim: no wrap from the far edges, pre-render ignored, then a real hit
    set_aim(0, 0);
    step(mk("wrap_hv",   340, 261, 255, 255, 255, 1, 0, 0,  0, 0));
    step(mk("wrap_v",      0, 261, 255, 255, 255, 1, 0, 0,  0, 0));
    step(mk("wrap_h",    340,   0, 255, 255, 255, 1, 0, 0,  0, 0));
    step(mk("prerender",   1, 511, 255, 255, 255, 1, 0, 0,  0, 0));
    step(mk("origin_hit",  0,   0, 255, 255, 255, 1, 0, 1, 20, 0));

    // Async reset in the middle of a hold
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("rst_hold.light",    32'(bus.light),    32'd0);
    check("rst_hold.hold_cnt", 32'(bus.hold_cnt), 32'd0);

    // Trigger: 3-clock press, stretch over 4 frame starts, second press ignored
    do_reset();
    set_aim(300, 100);
    step(mk("trig_a",   5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("trig_b",   5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("trig_c",   5, 5, 0, 0, 0, 1, 1, 0, 0, 1));
    step(mk("trig_hi",  5, 5, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("trig_fs1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    for (int i = 0; i < 3; i++) step(mk("trig_press2", 5, 5, 0, 0, 0, 1, 1, 0, 0, 1));
    for (int i = 0; i < 3; i++) step(mk("trig_rel2",   5, 5, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("trig_fs2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("trig_fs3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("trig_fs4", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) step(mk("trig_idle", 5, 5, 0, 0, 0, 1, 0, 0, 0, 0));

    // Edge coinciding with frame_start loads the full count without decrementing
    step(mk("co_a",  5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("co_b",  5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("co_c",  0, 0, 0, 0, 0, 1, 1, 0, 0, 1));
    step(mk("co_f1", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("co_f2", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("co_f3", 0, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    step(mk("co_f4", 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));

    // Async reset mid-pulse clears trigger_out before any clock edge
    step(mk("rp_a", 5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("rp_b", 5, 5, 0, 0, 0, 1, 1, 0, 0, 0));
    step(mk("rp_c", 5, 5, 0, 0, 0, 1, 1, 0, 0, 1));
    #2 reset_n = 1'b0;
    #1;
    check("rst_pulse.trigger_out", 32'(bus.trigger_out), 32'd0);
    check("rst_pulse.light",       32'(bus.light),       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
